// File: rtl/ctrl_transfer_pkg.sv
// Shared encodings for the control-transfer predictor: branch funct3 codes,
// next-PC select values, BHT counter reset value and branch-condition helpers.
package ctrl_transfer_pkg;

  localparam logic [2:0] BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] BRANCH_BNE  = 3'b001;
  localparam logic [2:0] BRANCH_BLT  = 3'b100;
  localparam logic [2:0] BRANCH_BGE  = 3'b101;
  localparam logic [2:0] BRANCH_BLTU = 3'b110;
  localparam logic [2:0] BRANCH_BGEU = 3'b111;

  typedef enum logic [1:0] {
    PC_SEL_SEQ     = 2'b00,
    PC_SEL_TARGET  = 2'b01,
    PC_SEL_JALR    = 2'b10,
    PC_SEL_RECOVER = 2'b11
  } pc_sel_e;

  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  function automatic logic branch_legal(input logic [2:0] funct3);
    return (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       bit0,
                                       input logic       eq_zero);
    logic taken;
    taken = 1'b0;
    case (funct3)
      BRANCH_BEQ:                taken = eq_zero;
      BRANCH_BNE:                taken = !eq_zero;
      BRANCH_BLT, BRANCH_BLTU:   taken = bit0;
      BRANCH_BGE, BRANCH_BGEU:   taken = !bit0;
      default:                   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty is ignored, and push+pop together replaces the top.
module return_address_stack
  import ctrl_transfer_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             empty;

  assign empty   = (cnt_q == '0);
  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);
  assign valid   = !empty;
  assign top     = empty ? '0 : mem_q[ptr_q];

  // The pointer wraps naturally, so a push on a full stack lands on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else if (push && pop && !empty) begin
      mem_q[ptr_q] <= push_data;
    end else if (push) begin
      mem_q[ptr_inc] <= push_data;
      ptr_q          <= ptr_inc;
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_transfer_predictor.sv
// Fetch-side direction predictor (2-bit BHT) plus execute-side resolution of
// branches/jumps: next-PC select, flush, mispredict counting and RAS upkeep.
module control_transfer_predictor
  import ctrl_transfer_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            branch_en,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [2:0]      inst_funct3,
  input  logic            result_bit0,
  input  logic            result_eq_zero,
  input  logic            ex_pred_taken,
  input  logic            ex_rd_link,
  input  logic            ex_rs1_link,
  input  logic [XLEN-1:0] ex_link_addr,
  output logic [1:0]      pc_sel,
  output logic            flush,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_branch, is_jal, is_jalr;
  logic             actual_taken;
  logic             bht_update;
  logic             mispredict;
  logic             ras_push, ras_pop;
  pc_sel_e          pc_sel_d;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign pred_taken = if_valid && bht_q[if_idx][1];

  assign is_branch    = ex_valid && branch_en;
  assign is_jal       = ex_valid && !branch_en && jal_en;
  assign is_jalr      = ex_valid && !branch_en && !jal_en && jalr_en;
  assign actual_taken = branch_cond(inst_funct3, result_bit0, result_eq_zero);

  always_comb begin
    pc_sel_d   = PC_SEL_SEQ;
    flush      = 1'b0;
    bht_update = 1'b0;
    mispredict = 1'b0;
    if (is_branch) begin
      if (branch_legal(inst_funct3)) begin
        bht_update = 1'b1;
        if (actual_taken && !ex_pred_taken) begin
          pc_sel_d   = PC_SEL_TARGET;
          flush      = 1'b1;
          mispredict = 1'b1;
        end else if (!actual_taken && ex_pred_taken) begin
          pc_sel_d   = PC_SEL_RECOVER;
          flush      = 1'b1;
          mispredict = 1'b1;
        end
      end
    end else if (is_jal) begin
      pc_sel_d = PC_SEL_TARGET;
      flush    = 1'b1;
    end else if (is_jalr) begin
      pc_sel_d = PC_SEL_JALR;
      flush    = 1'b1;
    end
  end

  assign pc_sel = pc_sel_d;

  // A jalr with both link flags set asserts push and pop; the RAS treats it as replace-top.
  assign ras_push = (is_jal || is_jalr) && ex_rd_link;
  assign ras_pop  = is_jalr && ex_rs1_link;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_CNT_RESET;
    end else if (bht_update) begin
      if (actual_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mispredict_count <= '0;
    else if (mispredict) mispredict_count <= mispredict_count + 32'd1;
  end

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ex_link_addr),
    .top       (ras_top),
    .valid     (ras_valid)
  );

endmodule
